seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
- Sequencing controller for the team's four-consecutive-equal-bit detector (serial input w, registered Moore flag z).
- Accepts a parallel word from a requester, clears the detector, then serializes the word MSB-first onto the detector input.
- Collects the detector's z response per bit and returns a match count and the first-match bit index to the requester.

Parameters:
- WIDTH, 8, bits per word serialized; must be >= 1.
- CNT_W, 4, width of match_cnt and first_hit; must satisfy 2^CNT_W - 1 >= WIDTH.

Ports:
- CLK  in  1  single clock, all state updates on rising edge.
- res  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- din  in  WIDTH  word captured when start is accepted.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- done  out  1  one-cycle pulse; results valid from this cycle.
- hit  out  1  match_cnt != 0, held with results.
- match_cnt  out  CNT_W  number of bits after which the detector z was 1.
- first_hit  out  CNT_W  index (0 = MSB) of first bit giving z=1; all-ones if none.
- det_clr  out  1  active-high clear to the detector.
- det_w  out  1  serial bit to the detector.
- det_z  in  1  detector output flag.

Behaviour:
- Reset (res=1 at an edge): state returns to IDLE; busy=0, done=0, hit=0, match_cnt=0, first_hit=all-ones, det_w=0. det_clr = res OR (state==CLEAR), so the detector is cleared together with the controller. Reset mid-operation aborts with no done pulse.
- States: IDLE, CLEAR, SHIFT, FLUSH, DONE.
- IDLE: det_clr=0, det_w=0, busy=0.
  - On start=1, at the edge: load din into the shift register, zero bit_idx, match_cnt=0, first_hit=all-ones, then go to CLEAR.
  - start=0: stay in IDLE. Results from the previous word are held.
- CLEAR (1 cycle): det_clr=1, det_w=0; then go to SHIFT.
- SHIFT (WIDTH cycles):
  - det_w = shift register MSB; each edge shifts left and increments bit_idx.
  - After the cycle with bit_idx = WIDTH-1, go to FLUSH.
- Detector is registered, so det_z in a cycle reflects the bit presented in the previous cycle.
  - Sample det_z in SHIFT cycles with bit_idx >= 1 (credited to bit bit_idx-1) and in FLUSH (credited to bit WIDTH-1).
  - det_z in the first SHIFT cycle is ignored.
- On a sampled det_z=1:
  - match_cnt increments, saturating at all-ones.
  - If first_hit is all-ones, first_hit takes the credited index.
- FLUSH (1 cycle): det_w=0; then go to DONE.
- DONE (1 cycle): done=1, busy=1, hit = (match_cnt != 0); then go to IDLE.
- Latency: start is sampled at edge t0.
  - CLEAR occupies cycle t0+1, SHIFT cycles t0+2..t0+WIDTH+1, FLUSH cycle t0+WIDTH+2.
  - done=1 in cycle t0+WIDTH+3 (cycle 11 for WIDTH=8).
- start while busy: ignored, with no queueing. start high in the DONE cycle is also ignored.
- A new start is accepted in the first IDLE cycle following DONE; minimum back-to-back spacing is WIDTH+4 cycles.
- Unused state encodings go to IDLE on the next edge.

Decomposition:
- Shared package:
  - state encoding constants (3-bit IDLE=0, CLEAR=1, SHIFT=2, FLUSH=3, DONE=4);
  - FIRST_NONE sentinel (all-ones of CNT_W);
  - the detector run-length constant 4, for bench reference.
- One natural sub-module, seq_piso_shreg: WIDTH-bit parallel-load, shift-left register with load/shift enables and MSB output.
- FSM, counters and result registers stay in seq_det_ctrl.

Test Plan:
- din=8'h0F, start pulse, real detector attached -> done in cycle 11, match_cnt=2, first_hit=3, hit=1.
- din=8'h00 -> match_cnt=5 (bits 3..7), first_hit=3, hit=1. Then din=8'hFF back-to-back at minimum spacing -> match_cnt=5, first_hit=3; det_clr pulses once before each word.
- din=8'hAA -> match_cnt=0, first_hit=4'hF, hit=0; det_w trace 1,0,1,0,1,0,1,0 in SHIFT cycles t0+2..t0+9.
- start held high for 20 cycles with din changing every cycle -> only the value at acceptance is processed; a second acceptance occurs only in IDLE after DONE; busy is never low between acceptance and DONE.
- res=1 during SHIFT bit 5 -> next cycle all outputs at reset values, det_clr=1 while res=1, no done pulse. A subsequent start with din=8'h0F gives match_cnt=2, first_hit=3.

Source files
------------

// File: rtl/seq_det_ctrl_pkg.sv
// Shared encodings and constants for the detector sequencing controller.
// Pure declarations; no timing or flow-control behaviour lives here.
package seq_det_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam int DEF_CNT_W = 4;

    // first_hit value meaning "no bit produced a match" at the default width
    localparam logic [DEF_CNT_W-1:0] FIRST_NONE = {DEF_CNT_W{1'b1}};

    // Run length at which the attached detector raises z
    localparam int DET_RUN_LEN = 4;

endpackage

// File: rtl/seq_piso_shreg.sv
// Parallel-load, shift-left register exposing its MSB; load wins over shift.
// Zero latency from register to msb_o; no backpressure, enables are obeyed every cycle.
module seq_piso_shreg
    import seq_det_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end else if (shift_i) begin
            data_q <= data_q << 1;
        end
    end

    assign msb_o = data_q[WIDTH-1];

endmodule

// File: rtl/seq_det_ctrl.sv
// Clears the run-length detector, streams a word into it MSB-first and tallies its z flags.
// done arrives WIDTH+3 cycles after start is accepted; start is ignored (not queued) while busy.
module seq_det_ctrl
    import seq_det_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             res,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] first_hit,
    output logic             det_clr,
    output logic             det_w,
    input  logic             det_z
);

    localparam logic [CNT_W-1:0] NONE     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] bit_idx_q;
    logic [CNT_W-1:0] match_cnt_q;
    logic [CNT_W-1:0] match_cnt_d;
    logic [CNT_W-1:0] first_hit_q;
    logic [CNT_W-1:0] first_hit_d;
    logic [CNT_W-1:0] credit_idx;
    logic             sample;
    logic             load;
    logic             shift;
    logic             msb;

    assign load  = (state_q == S_IDLE) && start && !res;
    assign shift = (state_q == S_SHIFT) && !res;

    seq_piso_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk_i   (CLK),
        .rst_i   (res),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (din),
        .msb_o   (msb)
    );

    // The detector is registered, so z seen now belongs to the bit sent last cycle.
    always_comb begin
        sample      = 1'b0;
        credit_idx  = bit_idx_q - CNT_W'(1);
        match_cnt_d = match_cnt_q;
        first_hit_d = first_hit_q;
        if (state_q == S_SHIFT) begin
            sample = (bit_idx_q != '0);
        end else if (state_q == S_FLUSH) begin
            sample     = 1'b1;
            credit_idx = LAST_IDX;
        end
        if (sample && det_z) begin
            if (match_cnt_q != NONE) begin
                match_cnt_d = match_cnt_q + CNT_W'(1);
            end
            if (first_hit_q == NONE) begin
                first_hit_d = credit_idx;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (res) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bit_idx_q   <= '0;
            match_cnt_q <= '0;
            first_hit_q <= NONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q     <= S_CLEAR;
                        busy_q      <= 1'b1;
                        bit_idx_q   <= '0;
                        match_cnt_q <= '0;
                        first_hit_q <= NONE;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    match_cnt_q <= match_cnt_d;
                    first_hit_q <= first_hit_d;
                    bit_idx_q   <= bit_idx_q + CNT_W'(1);
                    if (bit_idx_q == LAST_IDX) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    match_cnt_q <= match_cnt_d;
                    first_hit_q <= first_hit_d;
                    done_q      <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign match_cnt = match_cnt_q;
    assign first_hit = first_hit_q;
    assign hit       = (match_cnt_q != '0);
    assign det_clr   = res || (state_q == S_CLEAR);
    assign det_w     = (state_q == S_SHIFT) && msb;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl with a behavioural four-equal-bit detector attached.
module tb_seq_det_ctrl;
    import seq_det_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       res;
    logic       start;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic       hit;
    logic [3:0] match_cnt;
    logic [3:0] first_hit;
    logic       det_clr;
    logic       det_w;
    logic       det_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_det_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK       (clk),
        .res       (res),
        .start     (start),
        .din       (din),
        .busy      (busy),
        .done      (done),
        .hit       (hit),
        .match_cnt (match_cnt),
        .first_hit (first_hit),
        .det_clr   (det_clr),
        .det_w     (det_w),
        .det_z     (det_z)
    );

    // Detector: z goes high once the last DET_RUN_LEN received bits were equal.
    int   det_run  = 0;
    logic det_last = 1'b0;
    always @(posedge clk) begin
        if (det_clr) begin
            det_run  <= 0;
            det_last <= 1'b0;
        end else begin
            if (det_run != 0 && det_w == det_last)
                det_run <= (det_run < 7) ? det_run + 1 : det_run;
            else
                det_run <= 1;
            det_last <= det_w;
        end
    end
    assign det_z = (det_run >= DET_RUN_LEN);

    // Reference: a bit counts when it ends a run of at least DET_RUN_LEN equal bits.
    function automatic void model(input logic [7:0] d, output logic [3:0] cnt,
                                  output logic [3:0] first);
        int run;
        run   = 0;
        cnt   = 4'd0;
        first = FIRST_NONE;
        for (int i = 0; i < 8; i++) begin
            if (i > 0 && d[7-i] == d[8-i]) run++;
            else run = 1;
            if (run >= DET_RUN_LEN) begin
                if (cnt != 4'hF) cnt = cnt + 4'd1;
                if (first == FIRST_NONE) first = 4'(i);
            end
        end
    endfunction

    // Presents one word in the next cycle and follows it until done or a cycle budget runs out.
    task automatic run_word(input logic [7:0] d, output int lat, output int clr_pulses,
                            output int busy_gaps, output logic [7:0] wtrace);
        lat        = -1;
        clr_pulses = 0;
        busy_gaps  = 0;
        wtrace     = 8'h00;
        @(negedge clk);
        start = 1'b1;
        din   = d;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (det_clr) clr_pulses++;
            if (!busy) busy_gaps++;
            if (k >= 2 && k <= 9) wtrace[9-k] = det_w;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_word(input string name, input logic [7:0] d);
        int lat, clr, gaps;
        logic [7:0] wt;
        logic [3:0] ec, ef;
        model(d, ec, ef);
        run_word(d, lat, clr, gaps, wt);
        checks++;
        if (lat !== 11) begin errors++; $display("FAIL %s latency got %0d want 11", name, lat); end
        checks++;
        if (match_cnt !== ec) begin errors++; $display("FAIL %s match_cnt got %0d want %0d", name, match_cnt, ec); end
        checks++;
        if (first_hit !== ef) begin errors++; $display("FAIL %s first_hit got %0d want %0d", name, first_hit, ef); end
        checks++;
        if (hit !== (ec != 0)) begin errors++; $display("FAIL %s hit got %b want %b", name, hit, ec != 0); end
        checks++;
        if (clr !== 1) begin errors++; $display("FAIL %s det_clr pulses got %0d want 1", name, clr); end
        checks++;
        if (gaps !== 0) begin errors++; $display("FAIL %s busy low cycles got %0d want 0", name, gaps); end
        checks++;
        if (wt !== d) begin errors++; $display("FAIL %s det_w trace got %h want %h", name, wt, d); end
    endtask

    task automatic test_reset();
        res   = 1'b1;
        start = 1'b0;
        din   = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (det_clr !== 1'b1) begin errors++; $display("FAIL reset det_clr got %b want 1", det_clr); end
        checks++;
        if ({busy, done, hit, det_w} !== 4'b0000) begin
            errors++; $display("FAIL reset flags busy/done/hit/det_w got %b want 0000", {busy, done, hit, det_w});
        end
        checks++;
        if (match_cnt !== 4'd0 || first_hit !== FIRST_NONE) begin
            errors++; $display("FAIL reset results got %0d/%0d want 0/15", match_cnt, first_hit);
        end
        res = 1'b0;
        @(negedge clk);
        checks++;
        if (det_clr !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle det_clr/busy got %b/%b want 0/0", det_clr, busy);
        end
    endtask

    task automatic test_basic();
        check_word("w0F", 8'h0F);
        check_word("wAA", 8'hAA);
    endtask

    task automatic test_back_to_back();
        check_word("b2b_00", 8'h00);
        check_word("b2b_FF", 8'hFF);
        check_word("b2b_C3", 8'hC3);
    endtask

    task automatic test_hold_results();
        logic [3:0] ec, ef;
        check_word("hold_F0", 8'hF0);
        model(8'hF0, ec, ef);
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL hold done/busy got %b/%b want 0/0", done, busy);
        end
        checks++;
        if (match_cnt !== ec || first_hit !== ef) begin
            errors++; $display("FAIL hold results got %0d/%0d want %0d/%0d", match_cnt, first_hit, ec, ef);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check_word($sformatf("rand%0d_%h", i, d), d);
        end
    endtask

    task automatic test_start_held();
        logic [7:0] r[20];
        int first_done, second_done, bad_busy;
        logic [3:0] gc1, gf1, gc2, gf2, ec, ef;
        logic exp_busy;
        first_done  = -1;
        second_done = -1;
        bad_busy    = 0;
        gc1 = 4'd0; gf1 = 4'd0; gc2 = 4'd0; gf2 = 4'd0;
        for (int n = 0; n < 20; n++) r[n] = 8'($urandom);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n >= 1) begin
                if (done) begin
                    if (first_done < 0) begin
                        first_done = n; gc1 = match_cnt; gf1 = first_hit;
                    end else if (second_done < 0) begin
                        second_done = n; gc2 = match_cnt; gf2 = first_hit;
                    end
                end
                exp_busy = (n <= 11) || (n >= 13 && n <= 23);
                if (busy !== exp_busy) bad_busy++;
            end
            if (n < 20) begin
                start = 1'b1;
                din   = r[n];
            end else begin
                start = 1'b0;
            end
            if (second_done >= 0) break;
        end
        start = 1'b0;
        checks++;
        if (first_done !== 11) begin errors++; $display("FAIL held first done cycle got %0d want 11", first_done); end
        model(r[0], ec, ef);
        checks++;
        if (gc1 !== ec || gf1 !== ef) begin
            errors++; $display("FAIL held word1 got %0d/%0d want %0d/%0d", gc1, gf1, ec, ef);
        end
        checks++;
        if (second_done !== 23) begin errors++; $display("FAIL held second done cycle got %0d want 23", second_done); end
        model(r[12], ec, ef);
        checks++;
        if (gc2 !== ec || gf2 !== ef) begin
            errors++; $display("FAIL held word2 got %0d/%0d want %0d/%0d", gc2, gf2, ec, ef);
        end
        checks++;
        if (bad_busy !== 0) begin errors++; $display("FAIL held busy profile wrong cycles got %0d want 0", bad_busy); end
    endtask

    task automatic test_reset_abort();
        int dones;
        dones = 0;
        @(negedge clk);
        start = 1'b1;
        din   = 8'hFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, hit, det_w, det_clr} !== 5'b00001) begin
            errors++; $display("FAIL abort busy/done/hit/det_w/det_clr got %b want 00001", {busy, done, hit, det_w, det_clr});
        end
        checks++;
        if (match_cnt !== 4'd0 || first_hit !== FIRST_NONE) begin
            errors++; $display("FAIL abort results got %0d/%0d want 0/15", match_cnt, first_hit);
        end
        res = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL abort done pulses got %0d want 0", dones); end
        check_word("after_abort_0F", 8'h0F);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_hold_results();
        test_random();
        test_start_held();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
